// File: rtl/ceil_div_seq_pkg.sv
// Shared types and helpers for the sequential ceiling divider.
package ceil_div_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } ceil_div_state_e;

   // Width of the step counter that walks through WIDTH quotient bits.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/ceil_div_seq_if.sv
// Operand/result handshake bundle of the ceiling divider.
// Signal suffixes are relative to the divider (slave side).
interface ceil_div_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] dividend_i;
   logic [WIDTH-1:0] divisor_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] quotient_o;
   logic             exact_o;
   logic             div_zero_o;

   // Operand source / result consumer.
   modport master (
      output in_valid_i, dividend_i, divisor_i, out_ready_i,
      input  in_ready_o, out_valid_o, quotient_o, exact_o, div_zero_o
   );

   // The divider itself.
   modport slave (
      input  in_valid_i, dividend_i, divisor_i, out_ready_i,
      output in_ready_o, out_valid_o, quotient_o, exact_o, div_zero_o
   );
endinterface

// File: rtl/div_restoring_step.sv
// One restoring division step: shift {rem,quo} left, trial-subtract the divisor.
module div_restoring_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic [WIDTH-1:0] quo_o
);
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   dvs_ext;
   logic [WIDTH-1:0] quo_sh;

   // Shift the next dividend bit into the remainder and restore on underflow.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      rem_sh  = (rem_i << 1) | {{WIDTH{1'b0}}, quo_i[WIDTH-1]};
      quo_sh  = quo_i << 1;
      dvs_ext = {1'b0, divisor_i};
      rem_o   = rem_sh;
      quo_o   = quo_sh;
      if (rem_sh >= dvs_ext) begin
         rem_o    = rem_sh - dvs_ext;
         quo_o[0] = 1'b1;
      end
   end
endmodule

// File: rtl/ceil_div_seq.sv
// Multi-cycle unsigned ceiling divider, one quotient bit per cycle,
// valid/ready on both sides and a single operation in flight.
module ceil_div_seq
   import ceil_div_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           flush_i,
   ceil_div_seq_if.slave  bus
);
   localparam int CW = cnt_width(WIDTH);

   ceil_div_state_e  state_q, state_d;
   logic [WIDTH:0]   rem_q, rem_nx;
   logic [WIDTH-1:0] quo_q, quo_nx;
   logic [WIDTH-1:0] dvs_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] quotient_q;
   logic             exact_q;
   logic             div_zero_q;

   logic in_fire, out_fire, last_step, dvs_zero;

   assign in_fire   = bus.in_valid_i && (state_q == IDLE);
   assign out_fire  = bus.out_ready_i && (state_q == DONE);
   assign last_step = (cnt_q == CW'(WIDTH - 1));
   assign dvs_zero  = (bus.divisor_i == '0);

   div_restoring_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvs_q),
      .rem_o     (rem_nx),
      .quo_o     (quo_nx)
   );

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; flush overrides every transition, including a handshake.
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (in_fire) state_d = dvs_zero ? DONE : BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Handshake and result outputs, decoded from the state and result registers.
   always_comb begin
      bus.in_ready_o  = (state_q == IDLE);
      bus.out_valid_o = (state_q == DONE);
      bus.quotient_o  = quotient_q;
      bus.exact_o     = exact_q;
      bus.div_zero_o  = div_zero_q;
   end

   // Operand latch, iteration datapath and result registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: this is a handful of control-visible flops, not a memory, so all of them are reset.
      if (!rst_ni) begin
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         cnt_q      <= '0;
         quotient_q <= '0;
         exact_q    <= 1'b0;
         div_zero_q <= 1'b0;
      end else if (!flush_i) begin
         unique case (state_q)
            IDLE: begin
               if (in_fire) begin
                  dvs_q <= bus.divisor_i;
                  if (dvs_zero) begin
                     quotient_q <= '1;
                     exact_q    <= 1'b0;
                     div_zero_q <= 1'b1;
                  end else begin
                     rem_q      <= '0;
                     quo_q      <= bus.dividend_i;
                     cnt_q      <= '0;
                     div_zero_q <= 1'b0;
                  end
               end
            end
            BUSY: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt_q <= cnt_q + CW'(1);
               if (last_step) begin
                  // ceil(a/b) <= a for b >= 1, so the round-up never wraps.
                  quotient_q <= quo_nx + {{(WIDTH-1){1'b0}}, (rem_nx != '0)};
                  exact_q    <= (rem_nx == '0);
               end
            end
            default: ;
         endcase
      end
   end

`ifndef SYNTHESIS
   // Result and valid hold steady while the consumer stalls.
   a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (bus.out_valid_o && !bus.out_ready_i && !flush_i) |=>
      (bus.out_valid_o && $stable(bus.quotient_o) && $stable(bus.exact_o) && $stable(bus.div_zero_o)));

   // Accepting and presenting are mutually exclusive.
   a_ready_valid_excl : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.in_ready_o && bus.out_valid_o));
`endif

endmodule
